// File: rtl/offset_move_scheduler.sv
// Frame-synchronous window position controller: captures move requests, grants one
// per frame round-robin, and keeps wrap-around start/end coordinates for the renderer.
module offset_move_scheduler #(
  parameter int HDR    = 640,
  parameter int VDR    = 480,
  parameter int CHAR_W = 8,
  parameter int CHAR_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] charSize,
  input  logic [3:0] moveReq,
  input  logic       frameEnd,
  output logic [9:0] posHorStart,
  output logic [9:0] posHorEnd,
  output logic [9:0] posVerStart,
  output logic [9:0] posVerEnd,
  output logic [3:0] moveAck,
  output logic       busy
);

  if (CHAR_W * 7 > HDR || CHAR_H * 7 > VDR) begin : g_size_check
    $error("character window at scale 7 exceeds the display resolution");
  end

  localparam logic [10:0] HDR_L = 11'(HDR);
  localparam logic [10:0] VDR_L = 11'(VDR);

  typedef enum logic [1:0] {WAIT, CALC, COMMIT} state_t;
  state_t state, next_state;

  logic [2:0]  scale, scale_in;
  logic [10:0] w_in, h_in, w_cur, h_cur;
  logic [3:0]  pend, prev_req, edges, clr;
  logic [1:0]  ptr, grant, idx, grant_q;
  logic        grant_valid, grant_made;

  function automatic logic [9:0] step_back(input logic [9:0] s, input logic [10:0] sz,
                                           input logic [10:0] res);
    logic [10:0] s11;
    s11 = {1'b0, s};
    return (s11 >= sz) ? 10'(s11 - sz) : 10'(s11 + res - sz);
  endfunction

  function automatic logic [9:0] step_fwd(input logic [9:0] s, input logic [10:0] sz,
                                          input logic [10:0] res);
    logic [10:0] sum;
    sum = {1'b0, s} + sz;
    return (sum >= res) ? 10'(sum - res) : 10'(sum);
  endfunction

  function automatic logic [9:0] end_of(input logic [9:0] s, input logic [10:0] sz,
                                        input logic [10:0] res);
    logic [10:0] e;
    e = {1'b0, s} + sz - 11'd1;
    return (e >= res) ? 10'(e - res) : 10'(e);
  endfunction

  function automatic logic [9:0] centre(input logic [10:0] sz, input logic [10:0] res);
    return 10'((res - sz) >> 1);
  endfunction

  assign scale_in = (charSize == 3'd0) ? 3'd1 : charSize;
  assign w_in     = 11'(CHAR_W) * 11'(scale_in);
  assign h_in     = 11'(CHAR_H) * 11'(scale_in);
  assign w_cur    = 11'(CHAR_W) * 11'(scale);
  assign h_cur    = 11'(CHAR_H) * 11'(scale);
  assign edges    = moveReq & ~prev_req;

  // Search ptr, ptr-1, ... so the last granted direction gets lowest priority next.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr - 2'(k);
      if (!grant_valid && pend[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

  assign clr = (state == CALC && grant_valid) ? (4'd1 << grant) : '0;

  always_comb begin
    next_state = state;
    case (state)
      WAIT:    if (frameEnd && !busy) next_state = CALC;
      CALC:    next_state = COMMIT;
      COMMIT:  next_state = WAIT;
      default: next_state = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= WAIT;
    else        state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      scale       <= scale_in;
      posHorStart <= centre(w_in, HDR_L);
      posHorEnd   <= end_of(centre(w_in, HDR_L), w_in, HDR_L);
      posVerStart <= centre(h_in, VDR_L);
      posVerEnd   <= end_of(centre(h_in, VDR_L), h_in, VDR_L);
      pend        <= '0;
      prev_req    <= '0;
      ptr         <= 2'd3;
      moveAck     <= '0;
      busy        <= 1'b0;
      grant_made  <= 1'b0;
      grant_q     <= '0;
    end else begin
      prev_req <= moveReq;
      pend     <= (pend & ~clr) | edges;
      moveAck  <= '0;
      busy     <= (state != WAIT);
      case (state)
        CALC: begin
          scale      <= scale_in;
          grant_made <= grant_valid;
          grant_q    <= grant;
          if (grant_valid) begin
            ptr <= grant - 2'd1;
            case (grant)
              2'd3: posHorStart <= step_back(posHorStart, w_in, HDR_L);
              2'd2: posHorStart <= step_fwd(posHorStart, w_in, HDR_L);
              2'd1: posVerStart <= step_back(posVerStart, h_in, VDR_L);
              default: posVerStart <= step_fwd(posVerStart, h_in, VDR_L);
            endcase
          end
        end
        COMMIT: begin
          posHorEnd <= end_of(posHorStart, w_cur, HDR_L);
          posVerEnd <= end_of(posVerStart, h_cur, VDR_L);
          if (grant_made) moveAck <= 4'd1 << grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule
